mac_accum_engine: RTL

MAC_ACCUM_ENGINE -- requirements
Module: mac_accum_engine

---
 rtl/mac_accum_engine.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mac_accum_engine.sv
// Multi-lane signed multiply-accumulate engine: accumulates k_len operand beats
// per lane, then drains one lane result per handshake and pulses done.
module mac_accum_engine #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int K_MAX  = 64,
  localparam int K_W   = $clog2(K_MAX + 1),
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     start,
  input  logic [K_W-1:0]           k_len,
  input  logic                     sat_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_CH*DATA_W-1:0]   in_a,
  input  logic [N_CH*DATA_W-1:0]   in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
    $error("ACC_W must be at least 2*DATA_W");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q [N_CH];
  logic signed [ACC_W-1:0]  acc_d [N_CH];
  logic [K_W-1:0]           cnt_q, cnt_d;
  logic [K_W-1:0]           klen_q, klen_d;
  logic [CH_W-1:0]          idx_q, idx_d;
  logic                     sat_q, sat_d;
  logic                     err_q, err_d;

  // One guard bit above the accumulator exposes overflow in the raw sum.
  function automatic logic signed [ACC_W-1:0] sat_wrap(
    input logic signed [ACC_W:0] sum,
    input logic                  sat
  );
    if (sat && (sum[ACC_W] != sum[ACC_W-1]))
      return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return sum[ACC_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] mac_step(
    input logic signed [ACC_W-1:0]  acc,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic                     sat
  );
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W:0]      sum;
    prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    sum  = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
    return sat_wrap(sum, sat);
  endfunction

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (k_len == '0 || k_len > K_W'(K_MAX)) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < N_CH; i++) acc_d[i] = '0;
            cnt_d   = '0;
            idx_d   = '0;
            klen_d  = k_len;
            sat_d   = sat_en;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          for (int i = 0; i < N_CH; i++)
            acc_d[i] = mac_step(acc_q[i], in_a[i*DATA_W +: DATA_W],
                                in_b[i*DATA_W +: DATA_W], sat_q);
          cnt_d = cnt_q + K_W'(1);
          if (cnt_q + K_W'(1) == klen_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx_q == CH_W'(N_CH - 1)) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + CH_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      for (int i = 0; i < N_CH; i++) acc_q[i] <= '0;
      cnt_q   <= '0;
      klen_q  <= '0;
      idx_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == ACCUM) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign out_ch    = out_valid ? idx_q : '0;
  assign out_data  = out_valid ? acc_q[idx_q] : '0;

endmodule
